burst_seq_gen: RTL

Parametrised multi-channel transmit burst sequencer for the beam scanner front end. On a trigger it drives NCH complementary P/N pulser pairs with a programmable half-period, burst length and per-channel start delay, all counted in CLK64 ticks; per-channel delays steer the transmitted beam. It replaces the fixed three-frequency burst divider and sits between the sequencer/control register block and the pulser drivers.

---
 rtl/burst_seq_gen_if.sv | 29 ++
 rtl/burst_seq_gen.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/burst_seq_gen_if.sv
// Control and pulser-drive signal bundle for the transmit burst sequencer.
// The control block drives through the master modport and the sequencer answers through slave.
interface burst_seq_gen_if #(
  parameter int unsigned HALF_W = 6,
  parameter int unsigned CYC_W  = 5,
  parameter int unsigned NCH    = 2,
  parameter int unsigned DLY_W  = 6
);
  logic                   WR_Cfg;
  logic [HALF_W-1:0]      CFG_HALF;
  logic [CYC_W-1:0]       CFG_CYCLES;
  logic [NCH*DLY_W-1:0]   CFG_DLY;
  logic                   TRIG;
  logic                   ABORT;
  logic [NCH-1:0]         BURST_P;
  logic [NCH-1:0]         BURST_N;
  logic                   BUSY;
  logic                   DONE;

  modport master (
    output WR_Cfg, CFG_HALF, CFG_CYCLES, CFG_DLY, TRIG, ABORT,
    input  BURST_P, BURST_N, BUSY, DONE
  );

  modport slave (
    input  WR_Cfg, CFG_HALF, CFG_CYCLES, CFG_DLY, TRIG, ABORT,
    output BURST_P, BURST_N, BUSY, DONE
  );
endinterface

// File: rtl/burst_seq_gen.sv
// Multi-channel transmit burst sequencer: per-channel delayed P/N pulse trains of
// programmable half-period and cycle count, counted in CLK64 ticks.
module burst_seq_gen #(
  parameter int unsigned HALF_W = 6,
  parameter int unsigned CYC_W  = 5,
  parameter int unsigned NCH    = 2,
  parameter int unsigned DLY_W  = 6
) (
  input logic            CLK64,
  input logic            RES_n,
  burst_seq_gen_if.slave bus
);

  typedef enum logic [0:0] {StIdle, StRun} gl_st_e;
  typedef enum logic [2:0] {StOff, StWait, StDrvP, StDrvN, StFin} ch_st_e;

  gl_st_e               gl_st_q;
  ch_st_e               ch_st_q [NCH];
  logic [DLY_W-1:0]     dc_q    [NCH];
  logic [HALF_W-1:0]    hc_q    [NCH];
  logic [CYC_W-1:0]     pc_q    [NCH];

  logic [HALF_W-1:0]    half_q;
  logic [CYC_W-1:0]     cyc_q;
  logic [NCH*DLY_W-1:0] dly_q;
  logic [HALF_W-1:0]    run_half_q;

  logic [NCH-1:0]       p_q;
  logic [NCH-1:0]       n_q;
  logic                 busy_q;
  logic                 done_q;

  logic [HALF_W-1:0]    half_eff;
  logic [HALF_W-1:0]    half_rl;
  logic [NCH-1:0]       ch_last;
  logic                 all_last;

  always_comb begin
    half_eff = (half_q == '0) ? HALF_W'(1) : half_q;
    half_rl  = run_half_q - HALF_W'(1);
    ch_last  = '0;
    // A channel counts as finished when it is in FIN or leaves its final N half this edge.
    for (int c = 0; c < NCH; c++) begin
      ch_last[c] = (ch_st_q[c] == StFin) ||
                   ((ch_st_q[c] == StDrvN) && (hc_q[c] == '0) && (pc_q[c] == CYC_W'(1)));
    end
    all_last = &ch_last;
  end

  always_ff @(posedge CLK64 or negedge RES_n) begin
    if (!RES_n) begin
      gl_st_q    <= StIdle;
      half_q     <= HALF_W'(4);
      cyc_q      <= CYC_W'(4);
      dly_q      <= '0;
      run_half_q <= HALF_W'(4);
      p_q        <= '0;
      n_q        <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      for (int c = 0; c < NCH; c++) begin
        ch_st_q[c] <= StOff;
        dc_q[c]    <= '0;
        hc_q[c]    <= '0;
        pc_q[c]    <= '0;
      end
    end else begin
      done_q <= 1'b0;

      // Burst start below reads the pre-write config because these are non-blocking.
      if (bus.WR_Cfg && !busy_q) begin
        half_q <= bus.CFG_HALF;
        cyc_q  <= bus.CFG_CYCLES;
        dly_q  <= bus.CFG_DLY;
      end

      if (bus.ABORT) begin
        gl_st_q <= StIdle;
        busy_q  <= 1'b0;
        p_q     <= '0;
        n_q     <= '0;
        for (int c = 0; c < NCH; c++) begin
          ch_st_q[c] <= StOff;
        end
      end else begin
        unique case (gl_st_q)
          StIdle: begin
            if (bus.TRIG) begin
              if (cyc_q == '0) begin
                done_q <= 1'b1;
              end else begin
                gl_st_q    <= StRun;
                busy_q     <= 1'b1;
                run_half_q <= half_eff;
                for (int c = 0; c < NCH; c++) begin
                  pc_q[c] <= cyc_q;
                  hc_q[c] <= half_eff - HALF_W'(1);
                  if (dly_q[c*DLY_W +: DLY_W] == '0) begin
                    ch_st_q[c] <= StDrvP;
                    p_q[c]     <= 1'b1;
                  end else begin
                    ch_st_q[c] <= StWait;
                    dc_q[c]    <= dly_q[c*DLY_W +: DLY_W] - DLY_W'(1);
                  end
                end
              end
            end
          end

          StRun: begin
            if (all_last) begin
              gl_st_q <= StIdle;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              p_q     <= '0;
              n_q     <= '0;
              for (int c = 0; c < NCH; c++) begin
                ch_st_q[c] <= StOff;
              end
            end else begin
              for (int c = 0; c < NCH; c++) begin
                unique case (ch_st_q[c])
                  StWait: begin
                    if (dc_q[c] == '0) begin
                      ch_st_q[c] <= StDrvP;
                      p_q[c]     <= 1'b1;
                      hc_q[c]    <= half_rl;
                    end else begin
                      dc_q[c] <= dc_q[c] - DLY_W'(1);
                    end
                  end
                  StDrvP: begin
                    if (hc_q[c] == '0) begin
                      ch_st_q[c] <= StDrvN;
                      p_q[c]     <= 1'b0;
                      n_q[c]     <= 1'b1;
                      hc_q[c]    <= half_rl;
                    end else begin
                      hc_q[c] <= hc_q[c] - HALF_W'(1);
                    end
                  end
                  StDrvN: begin
                    if (hc_q[c] == '0) begin
                      n_q[c] <= 1'b0;
                      if (pc_q[c] == CYC_W'(1)) begin
                        ch_st_q[c] <= StFin;
                      end else begin
                        ch_st_q[c] <= StDrvP;
                        p_q[c]     <= 1'b1;
                        pc_q[c]    <= pc_q[c] - CYC_W'(1);
                        hc_q[c]    <= half_rl;
                      end
                    end else begin
                      hc_q[c] <= hc_q[c] - HALF_W'(1);
                    end
                  end
                  default: begin
                    ch_st_q[c] <= ch_st_q[c];
                  end
                endcase
              end
            end
          end

          default: begin
            gl_st_q <= StIdle;
          end
        endcase
      end
    end
  end

  assign bus.BURST_P = p_q;
  assign bus.BURST_N = n_q;
  assign bus.BUSY    = busy_q;
  assign bus.DONE    = done_q;

endmodule
